// File: rtl/instr_sequencer_if.sv
// Handshake/bus bundle between the instruction sequencer and the rest of the 9-bit core.
// The sequencer attaches through the slave modport; the surrounding core (or bench) through master.
interface instr_sequencer_if #(
    parameter int PC_W = 10
);
    logic            Start;
    logic [8:0]      Instr;
    logic            Ldr;
    logic            Str;
    logic            BranchTaken;
    logic [PC_W-1:0] Target;
    logic [PC_W-1:0] Prog_ctr;
    logic [8:0]      Ir;
    logic            RegWe_gate;
    logic            MemWe_gate;
    logic            Busy;
    logic            Done;
    logic [15:0]     CycleCnt;
    logic [15:0]     InstrCnt;

    modport master (
        output Start, Instr, Ldr, Str, BranchTaken, Target,
        input  Prog_ctr, Ir, RegWe_gate, MemWe_gate, Busy, Done, CycleCnt, InstrCnt
    );

    modport slave (
        input  Start, Instr, Ldr, Str, BranchTaken, Target,
        output Prog_ctr, Ir, RegWe_gate, MemWe_gate, Busy, Done, CycleCnt, InstrCnt
    );
endinterface

// File: rtl/instr_sequencer.sv
// Multi-cycle FETCH/EXEC/MEM control sequencer: owns PC and IR, gates register-file
// and data-memory writes, and keeps saturating cycle/instruction counters.
module instr_sequencer #(
    parameter int         PC_W      = 10,
    parameter int         MEM_WAIT  = 1,
    parameter logic [8:0] HALT_CODE = 9'h1FF
) (
    input  logic             Clk,
    input  logic             Reset,
    instr_sequencer_if.slave bus
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_EXEC  = 3'd2;
    localparam logic [2:0] S_MEM   = 3'd3;
    localparam logic [2:0] S_HALT  = 3'd4;

    logic [2:0]      r_state;
    logic [PC_W-1:0] r_pc;
    logic [8:0]      r_ir;
    logic [2:0]      r_wait;
    logic [15:0]     r_cyc;
    logic [15:0]     r_icnt;

    logic            w_halt;
    logic            w_taken;
    logic            w_exec_wr;
    logic            w_mem_last;
    logic            w_retire;
    logic            w_busy;
    logic [PC_W-1:0] w_pc_next;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign w_halt     = (r_ir == HALT_CODE);
    assign w_taken    = (r_ir[8:5] == 4'b1001) ||
                        (((r_ir[8:6] == 3'b101) || (r_ir[8:6] == 3'b110)) && bus.BranchTaken);
    assign w_pc_next  = w_taken ? bus.Target : r_pc + PC_W'(1);
    // Halt takes priority over whatever the decoder makes of the reserved code.
    assign w_exec_wr  = (r_state == S_EXEC) && !w_halt && !bus.Ldr;
    assign w_mem_last = (r_state == S_MEM) && (r_wait == 3'd1);
    assign w_retire   = w_exec_wr || w_mem_last;
    assign w_busy     = (r_state == S_FETCH) || (r_state == S_EXEC) || (r_state == S_MEM);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_ir    <= '0;
            r_wait  <= '0;
            r_cyc   <= '0;
            r_icnt  <= '0;
        end else begin
            if (w_busy)
                r_cyc <= sat_inc16(r_cyc);
            if (w_retire) begin
                r_icnt <= sat_inc16(r_icnt);
                r_pc   <= w_pc_next;
            end
            case (r_state)
                S_IDLE, S_HALT: begin
                    if (bus.Start) begin
                        r_state <= S_FETCH;
                        r_pc    <= '0;
                        r_cyc   <= '0;
                        r_icnt  <= '0;
                    end
                end
                S_FETCH: begin
                    r_ir    <= bus.Instr;
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    if (w_halt)
                        r_state <= S_HALT;
                    else if (bus.Ldr) begin
                        r_state <= S_MEM;
                        r_wait  <= 3'(MEM_WAIT);
                    end else
                        r_state <= S_FETCH;
                end
                S_MEM: begin
                    if (r_wait == 3'd1)
                        r_state <= S_FETCH;
                    else
                        r_wait <= r_wait - 3'd1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Gates are combinational on state so an asynchronous reset drops them at once.
    assign bus.Prog_ctr   = r_pc;
    assign bus.Ir         = r_ir;
    assign bus.RegWe_gate = w_retire;
    assign bus.MemWe_gate = w_exec_wr && bus.Str;
    assign bus.Busy       = w_busy;
    assign bus.Done       = (r_state == S_HALT);
    assign bus.CycleCnt   = r_cyc;
    assign bus.InstrCnt   = r_icnt;

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: ROM/decoder/jump-LUT stand-ins plus an instruction-level
// reference model producing the expected per-cycle PC and write-gate trace.
module tb_instr_sequencer;

    localparam int         PC_W = 5;
    localparam int         MW   = 2;
    localparam logic [8:0] HALT = 9'h1FF;

    logic Clk = 1'b0;
    logic Reset;
    always #5 Clk = ~Clk;

    instr_sequencer_if #(.PC_W(PC_W)) bus ();

    instr_sequencer #(.PC_W(PC_W), .MEM_WAIT(MW), .HALT_CODE(HALT)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    logic [8:0] rom [32];
    logic       bt  [32];
    logic [4:0] tgt [32];

    // Decoder stand-in: 011 = load, 010 = store.
    assign bus.Instr       = rom[bus.Prog_ctr];
    assign bus.Ldr         = (bus.Ir[8:6] == 3'b011);
    assign bus.Str         = (bus.Ir[8:6] == 3'b010);
    assign bus.BranchTaken = bt[bus.Prog_ctr];
    assign bus.Target      = tgt[bus.Prog_ctr];

    int checks   = 0;
    int failures = 0;

    logic [4:0] e_pc [$];
    logic       e_rw [$];
    logic       e_mw [$];
    int         e_icnt;
    logic [4:0] e_fpc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [4:0] p, input logic rw, input logic mw);
        e_pc.push_back(p);
        e_rw.push_back(rw);
        e_mw.push_back(mw);
    endtask

    // Walks the program one instruction at a time and lists every busy cycle.
    task automatic model();
        logic [4:0] pc;
        logic [8:0] ins;
        bit         taken;
        pc = '0;
        e_pc.delete(); e_rw.delete(); e_mw.delete();
        e_icnt = 0;
        e_fpc  = '0;
        for (int step = 0; step < 100; step++) begin
            ins = rom[pc];
            push(pc, 1'b0, 1'b0);
            if (ins == HALT) begin
                push(pc, 1'b0, 1'b0);
                e_fpc = pc;
                return;
            end
            if (ins[8:6] == 3'b011) begin
                push(pc, 1'b0, 1'b0);
                for (int k = 1; k <= MW; k++) push(pc, k == MW, 1'b0);
            end else begin
                push(pc, 1'b1, ins[8:6] == 3'b010);
            end
            e_icnt++;
            taken = (ins[8:5] == 4'b1001) ||
                    (((ins[8:6] == 3'b101) || (ins[8:6] == 3'b110)) && bt[pc]);
            pc = taken ? tgt[pc] : 5'((int'(pc) + 1) % 32);
        end
        e_fpc = pc;
    endtask

    task automatic clear_prog();
        for (int p = 0; p < 32; p++) begin
            rom[p] = HALT;
            bt[p]  = 1'b0;
            tgt[p] = '0;
        end
    endtask

    task automatic do_start();
        @(negedge Clk);
        bus.Start = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        bus.Start = 1'b0;
    endtask

    task automatic run_prog(input string nm, input bit glitch);
        logic [15:0] c_hold, i_hold;
        model();
        do_start();
        chk({nm, "_cyc_clear"}, 32'(bus.CycleCnt), 32'd0);
        chk({nm, "_icnt_clear"}, 32'(bus.InstrCnt), 32'd0);
        chk({nm, "_done_fall"}, 32'(bus.Done), 32'd0);
        for (int n = 0; n < e_pc.size(); n++) begin
            chk($sformatf("%s_trace%0d{pc,rw,mw,busy}", nm, n),
                32'({bus.Prog_ctr, bus.RegWe_gate, bus.MemWe_gate, bus.Busy}),
                32'({e_pc[n], e_rw[n], e_mw[n], 1'b1}));
            if (glitch) bus.Start = 1'($urandom_range(0, 1));
            @(negedge Clk);
        end
        bus.Start = 1'b0;
        chk({nm, "_done"}, 32'({bus.Done, bus.Busy, bus.RegWe_gate, bus.MemWe_gate}), 32'b1000);
        chk({nm, "_cyccnt"}, 32'(bus.CycleCnt), 32'(e_pc.size()));
        chk({nm, "_instrcnt"}, 32'(bus.InstrCnt), 32'(e_icnt));
        chk({nm, "_final_pc"}, 32'(bus.Prog_ctr), 32'(e_fpc));
        c_hold = 16'(e_pc.size());
        i_hold = 16'(e_icnt);
        repeat (3) @(negedge Clk);
        chk({nm, "_hold"}, {bus.CycleCnt, bus.InstrCnt}, {c_hold, i_hold});
        chk({nm, "_hold_done"}, 32'(bus.Done), 32'd1);
    endtask

    task automatic gen_random();
        int         k;
        logic [5:0] lo;
        for (int p = 0; p < 31; p++) begin
            k  = $urandom_range(0, 6);
            lo = 6'($urandom);
            case (k)
                0:       rom[p] = {3'b000, lo};
                1:       rom[p] = {3'b001, lo};
                2:       rom[p] = {3'b011, lo};
                3:       rom[p] = {3'b010, lo};
                4:       rom[p] = {3'b101, lo};
                5:       rom[p] = {3'b110, lo};
                default: rom[p] = {4'b1001, lo[4:0]};
            endcase
            bt[p]  = 1'($urandom_range(0, 1));
            tgt[p] = 5'($urandom_range(p + 1, 31));
        end
        rom[31] = HALT;
        bt[31]  = 1'b0;
        tgt[31] = '0;
    endtask

    initial begin
        Reset     = 1'b1;
        bus.Start = 1'b0;
        clear_prog();
        repeat (2) @(negedge Clk);
        chk("reset_outputs",
            32'({bus.Prog_ctr, bus.Ir, bus.RegWe_gate, bus.MemWe_gate, bus.Busy, bus.Done}), 32'd0);
        chk("reset_counters", {bus.CycleCnt, bus.InstrCnt}, 32'd0);
        Reset = 1'b0;

        // Asynchronous reset in the EXEC cycle of a store.
        rom[0] = {3'b010, 6'h11};
        do_start();
        @(negedge Clk);
        chk("store_exec_memwe", 32'({bus.MemWe_gate, bus.RegWe_gate}), 32'b11);
        #2 Reset = 1'b1;
        #1;
        chk("reset_drops_gates", 32'({bus.MemWe_gate, bus.RegWe_gate}), 32'b00);
        @(negedge Clk);
        Reset = 1'b0;
        chk("post_reset_pc_ir", 32'({bus.Prog_ctr, bus.Ir}), 32'd0);
        chk("post_reset_busy_done", 32'({bus.Busy, bus.Done}), 32'd0);
        chk("post_reset_counters", {bus.CycleCnt, bus.InstrCnt}, 32'd0);

        clear_prog();
        rom[0] = {3'b000, 6'h0A};
        rom[1] = {3'b001, 6'h15};
        rom[2] = {4'b1000, 5'h03};
        run_prog("straight", 1'b0);
        chk("straight_counts", {bus.CycleCnt, bus.InstrCnt}, {16'd8, 16'd3});
        chk("straight_pc", 32'(bus.Prog_ctr), 32'd3);

        clear_prog();
        rom[0] = {3'b011, 6'h04};
        run_prog("load_wait", 1'b0);
        chk("load_wait_cycles", 32'(bus.CycleCnt), 32'd6);

        clear_prog();
        for (int p = 0; p < 5; p++) rom[p] = {3'b000, 6'(p)};
        rom[5] = {3'b110, 6'h02};
        tgt[5] = 5'd20;
        bt[5]  = 1'b1;
        run_prog("beq_taken", 1'b1);
        chk("beq_taken_pc", 32'(bus.Prog_ctr), 32'd20);
        bt[5] = 1'b0;
        run_prog("beq_not_taken", 1'b1);
        chk("beq_not_taken_pc", 32'(bus.Prog_ctr), 32'd6);

        clear_prog();
        rom[0] = {4'b1001, 5'h07};
        tgt[0] = 5'd3;
        bt[0]  = 1'b1;
        run_prog("jump_bt1", 1'b0);
        chk("jump_bt1_pc", 32'(bus.Prog_ctr), 32'd3);
        bt[0] = 1'b0;
        run_prog("jump_bt0", 1'b0);
        chk("jump_bt0_pc", 32'(bus.Prog_ctr), 32'd3);

        for (int r = 0; r < 12; r++) begin
            clear_prog();
            gen_random();
            run_prog($sformatf("rand%0d", r), 1'b1);
        end

        // Endless loop 0 -> 31 -> wrap to 0: exercises wrap, ignored Start and saturation.
        clear_prog();
        rom[0]  = {4'b1001, 5'h00};
        tgt[0]  = 5'd31;
        rom[31] = {3'b000, 6'h05};
        do_start();
        for (int n = 0; n <= 66000; n++) begin
            if (n == 1) bus.Start = 1'b1;
            if (n == 2) begin
                bus.Start = 1'b0;
                chk("loop_jump_pc", 32'(bus.Prog_ctr), 32'd31);
            end
            if (n == 4) chk("wrap_pc", 32'(bus.Prog_ctr), 32'd0);
            if (n == 65534) chk("cyc_before_sat", 32'(bus.CycleCnt), 32'hFFFE);
            if (n == 66000) begin
                chk("cyc_saturated", 32'(bus.CycleCnt), 32'hFFFF);
                chk("loop_instrcnt", 32'(bus.InstrCnt), 32'd33000);
            end
            if (n < 66000) @(negedge Clk);
        end
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        chk("final_reset", 32'({bus.Busy, bus.Done, bus.CycleCnt}), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
